wb_regfile: RTL and testbench

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile.sv | 65 ++++++
 tb/tb_wb_regfile.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Register file: 32 x 32-bit GPRs with two combinational read ports and a HI/LO pair.
// Optional write-to-read forwarding lets the same cycle's write-back value reach the read ports.
module wb_regfile #(
  parameter bit BYPASS_EN = 1'b1,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        wb_wd,
  input  logic              wb_wreg,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              wb_whilo,
  input  logic [DATA_W-1:0] wb_hi,
  input  logic [DATA_W-1:0] wb_lo,
  input  logic              re1,
  input  logic [4:0]        raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [4:0]        raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  logic [DATA_W-1:0] gpr [32];
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  // Reset clears the whole array asynchronously so stale values never survive a reset pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) gpr[i] <= '0;
      hi <= '0;
      lo <= '0;
    end else begin
      if (wb_wreg && (wb_wd != 5'd0)) gpr[wb_wd] <= wb_wdata;
      if (wb_whilo) begin
        hi <= wb_hi;
        lo <= wb_lo;
      end
    end
  end

  function automatic logic [DATA_W-1:0] read_port(
    input logic              rst_l,
    input logic              en,
    input logic [4:0]        addr,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] val;
    val = stored;
    if (!rst_l || !en || (addr == 5'd0)) val = '0;
    else if (BYPASS_EN && wb_wreg && (wb_wd == addr)) val = wb_wdata;
    return val;
  endfunction

  always_comb begin
    rdata1 = read_port(rst, re1, raddr1, gpr[raddr1]);
    rdata2 = read_port(rst, re2, raddr2, gpr[raddr2]);
  end

  assign hi_o = hi;
  assign lo_o = lo;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: a forwarding instance and a non-forwarding instance share stimulus.
// Expectations are queued by the stimulus and checked on the falling clock edge by a monitor.
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        wb_whilo;
  logic [31:0] wb_hi;
  logic [31:0] wb_lo;
  logic        re1;
  logic [4:0]  raddr1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata1, rdata2, hi_o, lo_o;
  logic [31:0] nb_rdata1, nb_rdata2, nb_hi_o, nb_lo_o;

  wb_regfile #(.BYPASS_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  wb_regfile #(.BYPASS_EN(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
    .re1(re1), .raddr1(raddr1), .rdata1(nb_rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(nb_rdata2),
    .hi_o(nb_hi_o), .lo_o(nb_lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output selectors used by the scoreboard entries.
  localparam int S_RD1 = 0, S_RD2 = 1, S_HI = 2, S_LO = 3, S_NB1 = 4, S_NB2 = 5, S_NBHI = 6;

  string       name_q [$];
  int          sel_q  [$];
  logic [31:0] exp_q  [$];

  int checks = 0;
  int errors = 0;

  task automatic expect_out(input string name, input int sel, input logic [31:0] exp);
    name_q.push_back(name);
    sel_q.push_back(sel);
    exp_q.push_back(exp);
  endtask

  // Advance to just after the next rising edge, where new inputs are driven.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_wreg  = 1'b0;
    wb_whilo = 1'b0;
    wb_wd    = 5'd0;
    wb_wdata = 32'h0;
    wb_hi    = 32'h0;
    wb_lo    = 32'h0;
  endtask

  always @(negedge clk) begin
    while (sel_q.size() > 0) begin
      string       nm;
      int          sel;
      logic [31:0] exp, act;
      nm  = name_q.pop_front();
      sel = sel_q.pop_front();
      exp = exp_q.pop_front();
      case (sel)
        S_RD1:   act = rdata1;
        S_RD2:   act = rdata2;
        S_HI:    act = hi_o;
        S_LO:    act = lo_o;
        S_NB1:   act = nb_rdata1;
        S_NB2:   act = nb_rdata2;
        default: act = nb_hi_o;
      endcase
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL %s got %h expected %h", nm, act, exp);
      end
    end
  end

  initial begin
    rst = 1'b0;
    idle_inputs();
    re1 = 1'b0; raddr1 = 5'd0;
    re2 = 1'b0; raddr2 = 5'd0;

    // Reset held across edges with a write presented: nothing may land.
    step();
    wb_wreg = 1'b1; wb_wd = 5'd9; wb_wdata = 32'h99;
    re1 = 1'b1; raddr1 = 5'd9;
    expect_out("reset_rd1", S_RD1, 32'h0);
    expect_out("reset_hi",  S_HI,  32'h0);
    expect_out("reset_lo",  S_LO,  32'h0);
    step();
    expect_out("reset_nb_rd1", S_NB1, 32'h0);

    // First edge after release performs the presented write.
    step();
    rst = 1'b1;
    wb_wreg = 1'b1; wb_wd = 5'd5; wb_wdata = 32'hDEADBEEF;
    re1 = 1'b1; raddr1 = 5'd9;
    re2 = 1'b1; raddr2 = 5'd5;
    expect_out("gpr9_after_rst_write", S_RD1, 32'h0);
    expect_out("bypass_rd2_5",         S_RD2, 32'hDEADBEEF);
    expect_out("nobypass_rd2_5",       S_NB2, 32'h0);
    step();
    idle_inputs();
    raddr1 = 5'd5; raddr2 = 5'd9;
    expect_out("rd1_gpr5",    S_RD1, 32'hDEADBEEF);
    expect_out("nb_rd1_gpr5", S_NB1, 32'hDEADBEEF);
    expect_out("rd2_gpr9",    S_RD2, 32'h0);
    step();
    re1 = 1'b0;
    expect_out("rd1_disabled", S_RD1, 32'h0);
    expect_out("rd2_gpr9_again", S_RD2, 32'h0);

    // Writes to address 0 are discarded and never forwarded.
    step();
    wb_wreg = 1'b1; wb_wd = 5'd0; wb_wdata = 32'h12345678;
    re1 = 1'b1; raddr1 = 5'd0;
    expect_out("zero_write_cycle", S_RD1, 32'h0);
    step();
    idle_inputs();
    re2 = 1'b1; raddr2 = 5'd0;
    expect_out("zero_after_rd1", S_RD1, 32'h0);
    expect_out("zero_after_rd2", S_RD2, 32'h0);

    // Forwarding versus stored state on both ports.
    step();
    wb_wreg = 1'b1; wb_wd = 5'd7; wb_wdata = 32'h1;
    step();
    wb_wreg = 1'b1; wb_wd = 5'd7; wb_wdata = 32'h2;
    raddr1 = 5'd7; raddr2 = 5'd7;
    expect_out("byp_rd1",   S_RD1, 32'h2);
    expect_out("byp_rd2",   S_RD2, 32'h2);
    expect_out("nobyp_rd1", S_NB1, 32'h1);
    expect_out("nobyp_rd2", S_NB2, 32'h1);
    step();
    idle_inputs();
    expect_out("post_edge_rd1",    S_RD1, 32'h2);
    expect_out("post_edge_nb_rd2", S_NB2, 32'h2);

    // Unknown data with enables low must not disturb state.
    step();
    wb_wd = 'x; wb_wdata = 'x; wb_hi = 'x; wb_lo = 'x;
    raddr1 = 5'd7; raddr2 = 5'd5;
    step();
    expect_out("hold_x_rd1", S_RD1, 32'h2);
    expect_out("hold_x_rd2", S_RD2, 32'hDEADBEEF);
    expect_out("hold_x_hi",  S_HI,  32'h0);

    // Simultaneous HI/LO and GPR write; HI/LO has no forwarding.
    step();
    idle_inputs();
    wb_whilo = 1'b1; wb_hi = 32'hAAAA0000; wb_lo = 32'h0000BBBB;
    wb_wreg = 1'b1; wb_wd = 5'd3; wb_wdata = 32'h33;
    expect_out("hi_not_yet", S_HI, 32'h0);
    step();
    idle_inputs();
    raddr1 = 5'd3;
    expect_out("hi_written",   S_HI,   32'hAAAA0000);
    expect_out("lo_written",   S_LO,   32'h0000BBBB);
    expect_out("nb_hi_written", S_NBHI, 32'hAAAA0000);
    expect_out("gpr3_written", S_RD1,  32'h33);

    // Fill every GPR with its index and HI/LO with ones.
    for (int i = 1; i < 32; i++) begin
      step();
      wb_wreg = 1'b1; wb_wd = i[4:0]; wb_wdata = i;
      wb_whilo = 1'b1; wb_hi = 32'hFFFFFFFF; wb_lo = 32'hFFFFFFFF;
    end
    step();
    idle_inputs();
    raddr1 = 5'd31; raddr2 = 5'd1;
    expect_out("fill_rd1_31", S_RD1, 32'd31);
    expect_out("fill_rd2_1",  S_RD2, 32'd1);
    expect_out("fill_hi",     S_HI,  32'hFFFFFFFF);
    expect_out("fill_lo",     S_LO,  32'hFFFFFFFF);

    // Mid-cycle reset pulse: outputs clear before any clock edge.
    step();
    rst = 1'b0;
    expect_out("async_rd1", S_RD1, 32'h0);
    expect_out("async_rd2", S_RD2, 32'h0);
    expect_out("async_hi",  S_HI,  32'h0);
    expect_out("async_lo",  S_LO,  32'h0);
    expect_out("async_nb1", S_NB1, 32'h0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    for (int i = 1; i < 32; i++) begin
      step();
      raddr1 = i[4:0]; raddr2 = 5'(32 - i);
      expect_out("cleared_rd1", S_RD1, 32'h0);
      expect_out("cleared_rd2", S_RD2, 32'h0);
    end
    step();
    expect_out("cleared_lo", S_LO, 32'h0);

    @(negedge clk);
    #1;
    checks++;
    if (sel_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", sel_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
